dynode_baseline_gen: RTL and testbench

Parametrised baseline restorer for one dynode ADC channel in the ROCSTAR dynode trigger path. It tracks the pulse-free ADC level to a fraction of an LSB and outputs three things: a baseline-corrected sample for event detection, a delayed raw sample for energy integration, and the baseline value for integration correction. Tracking freezes around detected events. Relative to the fixed 8-bit design, it generalises ADC width, delay depth, averaging window and fractional precision. It adds a programmable hold time, an external freeze, a baseline-valid flag, saturation, and an optional fast-acquire start.

---
 rtl/dynode_pkg.sv | 20 ++
 rtl/dynode_baseline_gen_if.sv | 42 ++++
 rtl/dynode_bl_delay.sv | 28 ++
 rtl/dynode_baseline_gen.sv | 154 +++++++++++++++
 tb/tb_dynode_baseline_gen.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dynode_pkg.sv
// dynode_pkg: width derivations and defaults shared by the dynode baseline
// restorer and the dynode integrator.
package dynode_pkg;

  localparam int unsigned STEP_DEFAULT = 1;

  // Tracked-baseline width: ADC bits, window-sum growth and fractional bits.
  function automatic int unsigned cv_width(input int unsigned adc_w,
                                           input int unsigned win_log2,
                                           input int unsigned frac_log2);
    return adc_w + win_log2 + frac_log2;
  endfunction

  // Window-sum width: full sum of 2^win_log2 samples without overflow.
  function automatic int unsigned sum_width(input int unsigned adc_w,
                                            input int unsigned win_log2);
    return adc_w + win_log2;
  endfunction

endpackage

// File: rtl/dynode_baseline_gen_if.sv
// dynode_baseline_gen_if: trigger inputs, ADC sample, configuration and
// baseline outputs of one dynode channel.
interface dynode_baseline_gen_if
  import dynode_pkg::*;
#(
  parameter int unsigned ADC_W     = 8,
  parameter int unsigned DLY_DEPTH = 16,
  parameter int unsigned WIN_LOG2  = 4,
  parameter int unsigned FRAC_LOG2 = 4,
  parameter int unsigned HOLD_W    = 5
);
  localparam int unsigned SEL_W = $clog2(DLY_DEPTH);
  localparam int unsigned SUM_W = sum_width(ADC_W, WIN_LOG2);
  localparam int unsigned CV_W  = cv_width(ADC_W, WIN_LOG2, FRAC_LOG2);

  logic              dyn_indet;
  logic              dyn_event;
  logic              dyn_pileup;
  logic              dyn_pudump;
  logic              blfreeze;
  logic [ADC_W-1:0]  dyn_data_in;
  logic [SEL_W-1:0]  dynadcdly;
  logic [HOLD_W-1:0] blholdtime;
  logic [SUM_W-1:0]  dyn_blcor;
  logic [ADC_W-1:0]  dyn_adcdly;
  logic [CV_W-1:0]   dyn_curval;
  logic              dyn_blvalid;
  logic              dyn_blhold;

  modport master (
    output dyn_indet, dyn_event, dyn_pileup, dyn_pudump, blfreeze,
           dyn_data_in, dynadcdly, blholdtime,
    input  dyn_blcor, dyn_adcdly, dyn_curval, dyn_blvalid, dyn_blhold
  );

  modport slave (
    input  dyn_indet, dyn_event, dyn_pileup, dyn_pudump, blfreeze,
           dyn_data_in, dynadcdly, blholdtime,
    output dyn_blcor, dyn_adcdly, dyn_curval, dyn_blvalid, dyn_blhold
  );

endinterface

// File: rtl/dynode_bl_delay.sv
// dynode_bl_delay: free-running tap delay line with a registered tap mux.
// Sample at cycle t appears on dout at t+sel+2.
module dynode_bl_delay #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             din,
  input  logic [$clog2(DEPTH)-1:0] sel,
  output logic [W-1:0]             dout
);

  logic [W-1:0] taps [DEPTH];

  // Shift every cycle and register the selected tap.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) taps[i] <= '0;
      dout <= '0;
    end else begin
      taps[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
      dout <= taps[sel];
    end
  end

endmodule

// File: rtl/dynode_baseline_gen.sv
// dynode_baseline_gen: baseline restorer for one dynode ADC channel.
// Tracks the pulse-free level in 2^-(WIN_LOG2+FRAC_LOG2) LSB units, freezes
// around events, and outputs corrected, delayed and baseline values.
// Optional: define DYN_BL_FASTACQ_EN to load the first window average
// directly into the tracker instead of slewing from zero.
module dynode_baseline_gen
  import dynode_pkg::*;
#(
  parameter int unsigned ADC_W     = 8,
  parameter int unsigned DLY_DEPTH = 16,
  parameter int unsigned WIN_LOG2  = 4,
  parameter int unsigned FRAC_LOG2 = 4,
  parameter int unsigned HOLD_W    = 5,
  parameter int unsigned STOP_DLY  = 3,
  parameter int unsigned STEP      = STEP_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  dynode_baseline_gen_if.slave bl
);

  localparam int unsigned SUM_W = sum_width(ADC_W, WIN_LOG2);
  localparam int unsigned CV_W  = cv_width(ADC_W, WIN_LOG2, FRAC_LOG2);
  localparam int unsigned CV_W1 = CV_W + 1;

  logic [ADC_W-1:0]    dlylast;
  logic [3:0]          ev_in;
  logic [3:0]          ev_prev;
  logic                stopbl;
  logic [STOP_DLY:0]   stop_pipe;
  logic                stoplast;
  logic [HOLD_W-1:0]   holdcnt;
  logic                hold_c;
  logic                blhold_q;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_add;
  logic [WIN_LOG2-1:0] scnt;
  logic [SUM_W-1:0]    newvalue;
  logic                newvld;
  logic                blvalid_q;
  logic [CV_W-1:0]     cv;
  logic [CV_W-1:0]     cv_next;
  logic [CV_W1-1:0]    cv_up;
  logic [SUM_W-1:0]    cv_hi;
  logic [SUM_W-1:0]    x_c;
  logic [SUM_W-1:0]    blcor_q;

  dynode_bl_delay #(
    .W     (ADC_W),
    .DEPTH (DLY_DEPTH)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (bl.dyn_data_in),
    .sel   (bl.dynadcdly),
    .dout  (dlylast)
  );

  assign ev_in    = {bl.dyn_indet, bl.dyn_event, bl.dyn_pileup, bl.dyn_pudump};
  assign stoplast = stop_pipe[STOP_DLY];
  assign hold_c   = stoplast | (holdcnt != '0) | bl.blfreeze;
  assign sum_add  = sum + SUM_W'(dlylast);
  assign cv_hi    = cv[CV_W-1:FRAC_LOG2];
  assign x_c      = SUM_W'(bl.dyn_data_in) << WIN_LOG2;

  // Stop pulse: one per rising edge of any event input, then delayed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_prev   <= '0;
      stopbl    <= 1'b0;
      stop_pipe <= '0;
    end else begin
      ev_prev      <= ev_in;
      stopbl       <= |(ev_in & ~ev_prev);
      stop_pipe[0] <= stopbl;
      for (int unsigned i = 1; i <= STOP_DLY; i++) stop_pipe[i] <= stop_pipe[i-1];
    end
  end

  // Hold counter: (re)loaded by each stop, then counts down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      holdcnt  <= '0;
      blhold_q <= 1'b0;
    end else begin
      blhold_q <= hold_c;
      if (stoplast)              holdcnt <= bl.blholdtime;
      else if (holdcnt != '0)    holdcnt <= holdcnt - HOLD_W'(1);
    end
  end

  // Window accumulator: full-window sums of the delayed sample; a hold
  // throws away the partial window.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum      <= '0;
      scnt     <= '0;
      newvalue <= '0;
      newvld   <= 1'b0;
    end else begin
      newvld <= 1'b0;
      if (blhold_q) begin
        sum  <= '0;
        scnt <= '0;
      end else if (scnt == '1) begin
        newvalue <= sum_add;
        newvld   <= 1'b1;
        sum      <= '0;
        scnt     <= '0;
      end else begin
        sum  <= sum_add;
        scnt <= scnt + WIN_LOG2'(1);
      end
    end
  end

  // Tracker next value: saturating slew toward the last window sum.
  always_comb begin
    cv_next = cv;
    cv_up   = {1'b0, cv} + CV_W1'(STEP);
`ifdef DYN_BL_FASTACQ_EN
    if (newvld && !blvalid_q) begin
      cv_next = CV_W'(newvalue) << FRAC_LOG2;
    end else
`endif
    if (!blhold_q) begin
      if (cv_hi < newvalue) begin
        cv_next = cv_up[CV_W] ? '1 : cv_up[CV_W-1:0];
      end else if (cv_hi > newvalue) begin
        cv_next = (cv < CV_W'(STEP)) ? '0 : cv - CV_W'(STEP);
      end
    end
  end

  // Tracker, valid flag and baseline-corrected sample registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cv        <= '0;
      blvalid_q <= 1'b0;
      blcor_q   <= '0;
    end else begin
      cv      <= cv_next;
      blcor_q <= (x_c > cv_hi) ? x_c - cv_hi : '0;
      if (newvld) blvalid_q <= 1'b1;
    end
  end

  assign bl.dyn_blcor   = blcor_q;
  assign bl.dyn_adcdly  = dlylast;
  assign bl.dyn_curval  = cv;
  assign bl.dyn_blvalid = blvalid_q;
  assign bl.dyn_blhold  = blhold_q;

endmodule

// File: tb/tb_dynode_baseline_gen.sv
// tb_dynode_baseline_gen: directed checks of the dynode baseline restorer
// with default parameters (8-bit ADC, 16 taps, 16-sample window, 4 frac bits,
// STOP_DLY=3, STEP=1).
module tb_dynode_baseline_gen;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  dynode_baseline_gen_if bl_if ();

  dynode_baseline_gen dut (
    .clk   (clk),
    .reset (reset),
    .bl    (bl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset             = 1'b1;
    bl_if.dyn_indet   = 1'b0;
    bl_if.dyn_event   = 1'b0;
    bl_if.dyn_pileup  = 1'b0;
    bl_if.dyn_pudump  = 1'b0;
    bl_if.blfreeze    = 1'b0;
    bl_if.dyn_data_in = 8'h00;
    bl_if.dynadcdly   = 4'd0;
    bl_if.blholdtime  = 5'd0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b1;
    bl_if.dyn_data_in = 8'hA5;
    tick();
    n_total++;
    if (bl_if.dyn_blcor !== 12'h000) $display("FAIL reset_blcor got %h want 000", bl_if.dyn_blcor);
    else n_pass++;
    n_total++;
    if (bl_if.dyn_adcdly !== 8'h00) $display("FAIL reset_adcdly got %h want 00", bl_if.dyn_adcdly);
    else n_pass++;
    n_total++;
    if (bl_if.dyn_curval !== 16'h0000) $display("FAIL reset_curval got %h want 0000", bl_if.dyn_curval);
    else n_pass++;
    n_total++;
    if (bl_if.dyn_blvalid !== 1'b0) $display("FAIL reset_blvalid got %b want 0", bl_if.dyn_blvalid);
    else n_pass++;
    n_total++;
    if (bl_if.dyn_blhold !== 1'b0) $display("FAIL reset_blhold got %b want 0", bl_if.dyn_blhold);
    else n_pass++;
    reset = 1'b0;
  endtask

  // Output in cycle 23 must be the sample driven in cycle 23-sel-2.
  task automatic test_delay_sweep();
    logic [7:0] d [24];
    for (int sel = 0; sel < 16; sel++) begin
      bl_if.dynadcdly = 4'(sel);
      for (int j = 0; j < 24; j++) begin
        tick();
        d[j] = 8'(j * 7 + sel * 13 + 5);
        bl_if.dyn_data_in = d[j];
      end
      n_total++;
      if (bl_if.dyn_adcdly !== d[21 - sel])
        $display("FAIL delay_tap%0d got %h want %h", sel, bl_if.dyn_adcdly, d[21 - sel]);
      else n_pass++;
    end
  endtask

  task automatic test_slew();
    logic [15:0] prev;
    logic [15:0] cur;
    int          bad_step;
    int          drift;
    apply_reset();
    bl_if.dyn_data_in = 8'h02;
    prev = 16'h0000;
    bad_step = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      cur = bl_if.dyn_curval;
      if (cur != prev && cur != prev + 16'd1) bad_step++;
      prev = cur;
      if (cur == 16'h0200) break;
    end
    n_total++;
    if (bl_if.dyn_curval !== 16'h0200) $display("FAIL slew_converge got %h want 0200", bl_if.dyn_curval);
    else n_pass++;
`ifndef DYN_BL_FASTACQ_EN
    n_total++;
    if (bad_step !== 0) $display("FAIL slew_unit_step got %0d bad steps want 0", bad_step);
    else n_pass++;
`endif
    n_total++;
    if (bl_if.dyn_blvalid !== 1'b1) $display("FAIL slew_blvalid got %b want 1", bl_if.dyn_blvalid);
    else n_pass++;
    drift = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bl_if.dyn_curval != 16'h0200) drift++;
    end
    n_total++;
    if (drift !== 0) $display("FAIL slew_settled got %0d drifted cycles want 0", drift);
    else n_pass++;
    // Freeze so the probe samples do not disturb the tracked level.
    bl_if.blfreeze = 1'b1;
    repeat (2) tick();
    bl_if.dyn_data_in = 8'h01;
    tick();
    n_total++;
    if (bl_if.dyn_blcor !== 12'h000) $display("FAIL blcor_underflow got %h want 000", bl_if.dyn_blcor);
    else n_pass++;
    bl_if.dyn_data_in = 8'h03;
    tick();
    n_total++;
    if (bl_if.dyn_blcor !== 12'h010) $display("FAIL blcor_above got %h want 010", bl_if.dyn_blcor);
    else n_pass++;
    bl_if.dyn_data_in = 8'h02;
    repeat (5) tick();
    bl_if.blfreeze = 1'b0;
    repeat (3) tick();
  endtask

  // Single event pulse at cycle t: hold visible t+6..t+29 for blholdtime=23.
  task automatic test_event_hold();
    int mism;
    int high_cnt;
    int cv_bad;
    logic exp_hold;
    bl_if.blholdtime = 5'd23;
    bl_if.dynadcdly  = 4'd12;
    repeat (20) tick();
    bl_if.dyn_event   = 1'b1;
    bl_if.dyn_data_in = 8'hFF;
    mism = 0;
    high_cnt = 0;
    cv_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      bl_if.dyn_event   = 1'b0;
      bl_if.dyn_data_in = (k < 8) ? 8'hFF : 8'h02;
      exp_hold = (k >= 6 && k <= 29);
      if (bl_if.dyn_blhold !== exp_hold) mism++;
      if (bl_if.dyn_blhold === 1'b1) high_cnt++;
      if (bl_if.dyn_curval != 16'h0200) cv_bad++;
    end
    n_total++;
    if (mism !== 0) $display("FAIL hold_window got %0d wrong cycles want 0", mism);
    else n_pass++;
    n_total++;
    if (high_cnt !== 24) $display("FAIL hold_length got %0d want 24", high_cnt);
    else n_pass++;
    n_total++;
    if (cv_bad !== 0) $display("FAIL hold_cv_during got %0d changed cycles want 0", cv_bad);
    else n_pass++;
    repeat (40) tick();
    n_total++;
    if (bl_if.dyn_curval !== 16'h0200) $display("FAIL hold_cv_after got %h want 0200", bl_if.dyn_curval);
    else n_pass++;
  endtask

  // Two inputs rising together and held high give exactly one stop.
  task automatic test_held_inputs();
    int high_cnt;
    bl_if.blholdtime = 5'd3;
    bl_if.dyn_event  = 1'b1;
    bl_if.dyn_pileup = 1'b1;
    high_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 12) begin
        bl_if.dyn_event  = 1'b0;
        bl_if.dyn_pileup = 1'b0;
      end
      if (bl_if.dyn_blhold === 1'b1) high_cnt++;
    end
    n_total++;
    if (high_cnt !== 4) $display("FAIL single_stop got %0d hold cycles want 4", high_cnt);
    else n_pass++;
  endtask

  task automatic test_freeze();
    int cv_bad;
    bl_if.blfreeze    = 1'b1;
    bl_if.dyn_data_in = 8'h50;
    n_total++;
    if (bl_if.dyn_blhold !== 1'b0) $display("FAIL freeze_latency0 got %b want 0", bl_if.dyn_blhold);
    else n_pass++;
    tick();
    n_total++;
    if (bl_if.dyn_blhold !== 1'b1) $display("FAIL freeze_latency1 got %b want 1", bl_if.dyn_blhold);
    else n_pass++;
    cv_bad = 0;
    for (int k = 2; k <= 100; k++) begin
      tick();
      if (bl_if.dyn_curval != 16'h0200) cv_bad++;
    end
    n_total++;
    if (cv_bad !== 0) $display("FAIL freeze_cv got %0d changed cycles want 0", cv_bad);
    else n_pass++;
    bl_if.blfreeze = 1'b0;
    tick();
    n_total++;
    if (bl_if.dyn_blhold !== 1'b0) $display("FAIL freeze_release got %b want 0", bl_if.dyn_blhold);
    else n_pass++;
    repeat (60) tick();
    n_total++;
    if (!(bl_if.dyn_curval > 16'h0200 && bl_if.dyn_curval <= 16'h023C))
      $display("FAIL freeze_slew_up got %h want 0201..023C", bl_if.dyn_curval);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bl_if.blholdtime  = 5'd23;
    bl_if.dyn_data_in = 8'h60;
    bl_if.dyn_event   = 1'b1;
    tick();
    bl_if.dyn_event = 1'b0;
    repeat (8) tick();
    n_total++;
    if (bl_if.dyn_blhold !== 1'b1) $display("FAIL midhold_pre got %b want 1", bl_if.dyn_blhold);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_total++;
    if (bl_if.dyn_blcor !== 12'h000) $display("FAIL midrst_blcor got %h want 000", bl_if.dyn_blcor);
    else n_pass++;
    n_total++;
    if (bl_if.dyn_adcdly !== 8'h00) $display("FAIL midrst_adcdly got %h want 00", bl_if.dyn_adcdly);
    else n_pass++;
    n_total++;
    if (bl_if.dyn_curval !== 16'h0000) $display("FAIL midrst_curval got %h want 0000", bl_if.dyn_curval);
    else n_pass++;
    n_total++;
    if (bl_if.dyn_blvalid !== 1'b0) $display("FAIL midrst_blvalid got %b want 0", bl_if.dyn_blvalid);
    else n_pass++;
    n_total++;
    if (bl_if.dyn_blhold !== 1'b0) $display("FAIL midrst_blhold got %b want 0", bl_if.dyn_blhold);
    else n_pass++;
    reset = 1'b0;
    bl_if.dyn_data_in = 8'h00;
    repeat (10) tick();
    n_total++;
    if (bl_if.dyn_blhold !== 1'b0) $display("FAIL postrst_blhold got %b want 0", bl_if.dyn_blhold);
    else n_pass++;
    n_total++;
    if (bl_if.dyn_curval !== 16'h0000) $display("FAIL postrst_curval got %h want 0000", bl_if.dyn_curval);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    test_reset();
    test_delay_sweep();
    test_slew();
    test_event_hold();
    test_held_inputs();
    test_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
